// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: owns the program counter, drives the next-PC mux selects,
// fetches the reset/interrupt vectors from imem[0]/imem[1] and sequences interrupt entry and return.
module pc_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stall,
  input  logic       branch_taken,
  input  logic [7:0] branch_addr,
  input  logic       ret_req,
  input  logic       is_rti,
  input  logic       stack_valid,
  input  logic [7:0] stack_data,
  input  logic       intr,
  input  logic [7:0] imem_data,
  input  logic [7:0] pc_new,
  output logic [7:0] pc,
  output logic [7:0] pc_plus_1,
  output logic [7:0] stack_addr,
  output logic [7:0] reset_addr,
  output logic [7:0] interrupt_addr,
  output logic       pc_src,
  output logic [1:0] pc_in_sel,
  output logic [7:0] imem_addr,
  output logic       push_req,
  output logic [7:0] push_data,
  output logic       flush,
  output logic       intr_ack,
  output logic       busy
);

  typedef enum logic [3:0] {
    VEC_RST, CAP_RST, LOAD_RST, RUN, INT_PUSH,
    VEC_INT, CAP_INT, LOAD_INT, RET_WAIT
  } state_e;

  localparam logic [1:0] SEL_INT    = 2'b00;
  localparam logic [1:0] SEL_STACK  = 2'b01;
  localparam logic [1:0] SEL_BRANCH = 2'b10;
  localparam logic [1:0] SEL_RESET  = 2'b11;

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] reset_addr_q, reset_addr_d;
  logic [7:0] interrupt_addr_q, interrupt_addr_d;
  logic       in_isr_q, in_isr_d;
  logic       is_rti_q, is_rti_d;

  // The branch target only feeds the external mux; it is not needed inside this block.
  logic branch_addr_unused;
  assign branch_addr_unused = ^branch_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= VEC_RST;
      pc_q             <= 8'h00;
      reset_addr_q     <= 8'h00;
      interrupt_addr_q <= 8'h00;
      in_isr_q         <= 1'b0;
      is_rti_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      reset_addr_q     <= reset_addr_d;
      interrupt_addr_q <= interrupt_addr_d;
      in_isr_q         <= in_isr_d;
      is_rti_q         <= is_rti_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    reset_addr_d     = reset_addr_q;
    interrupt_addr_d = interrupt_addr_q;
    in_isr_d         = in_isr_q;
    is_rti_d         = is_rti_q;
    imem_addr        = pc_q;
    pc_src           = 1'b0;
    pc_in_sel        = SEL_INT;
    push_req         = 1'b0;
    flush            = 1'b0;
    intr_ack         = 1'b0;

    case (state_q)
      VEC_RST: begin
        imem_addr = 8'h00;
        state_d   = CAP_RST;
      end
      CAP_RST: begin
        reset_addr_d = imem_data;
        state_d      = LOAD_RST;
      end
      LOAD_RST: begin
        pc_src    = 1'b1;
        pc_in_sel = SEL_RESET;
        pc_d      = pc_new;
        state_d   = RUN;
      end
      RUN: begin
        if (stall) begin
          state_d = RUN;
        end else if (ret_req) begin
          is_rti_d = is_rti;
          state_d  = RET_WAIT;
        end else if (branch_taken) begin
          pc_src    = 1'b1;
          pc_in_sel = SEL_BRANCH;
          pc_d      = pc_new;
          flush     = 1'b1;
        end else if (intr && !in_isr_q) begin
          // PC is frozen here; push_data carries the address to resume at.
          push_req = 1'b1;
          intr_ack = 1'b1;
          flush    = 1'b1;
          in_isr_d = 1'b1;
          state_d  = INT_PUSH;
        end else begin
          pc_d = pc_new;
        end
      end
      INT_PUSH: begin
        state_d = VEC_INT;
      end
      VEC_INT: begin
        imem_addr = 8'h01;
        state_d   = CAP_INT;
      end
      CAP_INT: begin
        interrupt_addr_d = imem_data;
        state_d          = LOAD_INT;
      end
      LOAD_INT: begin
        pc_src    = 1'b1;
        pc_in_sel = SEL_INT;
        pc_d      = pc_new;
        state_d   = RUN;
      end
      RET_WAIT: begin
        if (stack_valid) begin
          pc_src    = 1'b1;
          pc_in_sel = SEL_STACK;
          pc_d      = pc_new;
          flush     = 1'b1;
          if (is_rti_q) begin
            in_isr_d = 1'b0;
          end
          state_d = RUN;
        end
      end
      default: begin
        state_d = VEC_RST;
      end
    endcase
  end

  assign pc             = pc_q;
  assign pc_plus_1      = pc_q + 8'd1;
  assign stack_addr     = stack_data;
  assign reset_addr     = reset_addr_q;
  assign interrupt_addr = interrupt_addr_q;
  assign push_data      = pc_q;
  assign busy           = (state_q != RUN);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand-written reset/vector sequences,
// then randomized traffic against a cycle-level behavioural model.
module tb_pc_sequencer;

  logic       clk;
  logic       rst_n;
  logic       stall, branch_taken, ret_req, is_rti, stack_valid, intr;
  logic [7:0] branch_addr, stack_data, imem_data, pc_new;
  logic [7:0] pc, pc_plus_1, stack_addr, reset_addr, interrupt_addr, imem_addr, push_data;
  logic       pc_src, push_req, flush, intr_ack, busy;
  logic [1:0] pc_in_sel;

  logic [7:0] imem [256];
  int errors = 0;
  int checks = 0;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .ret_req(ret_req), .is_rti(is_rti),
    .stack_valid(stack_valid), .stack_data(stack_data), .intr(intr),
    .imem_data(imem_data), .pc_new(pc_new), .pc(pc), .pc_plus_1(pc_plus_1),
    .stack_addr(stack_addr), .reset_addr(reset_addr), .interrupt_addr(interrupt_addr),
    .pc_src(pc_src), .pc_in_sel(pc_in_sel), .imem_addr(imem_addr),
    .push_req(push_req), .push_data(push_data), .flush(flush),
    .intr_ack(intr_ack), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment: synchronous instruction memory and the external next-PC mux.
  always @(posedge clk) imem_data <= imem[imem_addr];

  always_comb begin
    pc_new = pc_plus_1;
    if (pc_src) begin
      case (pc_in_sel)
        2'b00:   pc_new = interrupt_addr;
        2'b01:   pc_new = stack_addr;
        2'b10:   pc_new = branch_addr;
        default: pc_new = reset_addr;
      endcase
    end
  end

  typedef struct {
    logic       st, br;
    logic [7:0] baddr;
    logic       it, rt, ri, sv;
    logic [7:0] sdata;
    logic [7:0] e_pc, e_imem;
    logic       e_busy, e_src;
    logic [1:0] e_sel;
    logic       e_flush, e_ack;
  } vec_t;

  vec_t vecs [22];

  task automatic applyStimulus(input logic st, input logic br, input logic [7:0] ba,
                               input logic it, input logic rt, input logic ri,
                               input logic sv, input logic [7:0] sd);
    stall = st; branch_taken = br; branch_addr = ba; intr = it;
    ret_req = rt; is_rti = ri; stack_valid = sv; stack_data = sd;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state: mode 0 boot, 1 run, 2 interrupt entry, 3 return wait.
  int         m_mode, m_cnt;
  logic [7:0] m_pc, m_rv, m_iv;
  logic       m_isr, m_rti;

  task automatic modelReset();
    m_mode = 0; m_cnt = 0; m_pc = 8'h00; m_rv = 8'h00; m_iv = 8'h00;
    m_isr = 1'b0; m_rti = 1'b0;
  endtask

  // Compare this cycle's outputs against the model, then advance the model one clock.
  task automatic modelStep();
    logic [7:0] e_imem, n_pc;
    logic       e_src, e_flush, e_ack;
    logic [1:0] e_sel;
    int         n_mode, n_cnt;
    e_imem = m_pc; n_pc = m_pc; e_src = 0; e_sel = 2'd0; e_flush = 0; e_ack = 0;
    n_mode = m_mode; n_cnt = m_cnt + 1;
    checkOutput("rnd_busy", 8'(busy), 8'(m_mode != 1));
    checkOutput("rnd_reset_addr", reset_addr, m_rv);
    checkOutput("rnd_interrupt_addr", interrupt_addr, m_iv);
    case (m_mode)
      0: begin
        if (m_cnt == 0) e_imem = 8'h00;
        if (m_cnt == 1) m_rv = imem[0];
        if (m_cnt == 2) begin e_src = 1; e_sel = 2'd3; n_pc = m_rv; n_mode = 1; end
      end
      1: begin
        if (stall) begin
        end else if (ret_req) begin
          m_rti = is_rti; n_mode = 3;
        end else if (branch_taken) begin
          e_src = 1; e_sel = 2'd2; e_flush = 1; n_pc = branch_addr;
        end else if (intr && !m_isr) begin
          e_ack = 1; e_flush = 1; m_isr = 1; n_mode = 2; n_cnt = 0;
        end else begin
          n_pc = m_pc + 8'd1;
        end
      end
      2: begin
        if (m_cnt == 1) e_imem = 8'h01;
        if (m_cnt == 2) m_iv = imem[1];
        if (m_cnt == 3) begin e_src = 1; e_sel = 2'd0; n_pc = m_iv; n_mode = 1; end
      end
      default: begin
        if (stack_valid) begin
          e_src = 1; e_sel = 2'd1; e_flush = 1; n_pc = stack_data; n_mode = 1;
          if (m_rti) m_isr = 0;
        end
      end
    endcase
    checkOutput("rnd_pc", pc, m_pc);
    checkOutput("rnd_pc_plus_1", pc_plus_1, m_pc + 8'd1);
    checkOutput("rnd_stack_addr", stack_addr, stack_data);
    checkOutput("rnd_imem_addr", imem_addr, e_imem);
    checkOutput("rnd_pc_src", 8'(pc_src), 8'(e_src));
    checkOutput("rnd_pc_in_sel", 8'(pc_in_sel), 8'(e_sel));
    checkOutput("rnd_flush", 8'(flush), 8'(e_flush));
    checkOutput("rnd_intr_ack", 8'(intr_ack), 8'(e_ack));
    checkOutput("rnd_push_req", 8'(push_req), 8'(e_ack));
    if (e_ack) checkOutput("rnd_push_data", push_data, m_pc);
    if (n_mode != m_mode && n_mode != 2) n_cnt = 0;
    m_mode = n_mode; m_cnt = n_cnt; m_pc = n_pc;
  endtask

  initial begin
    logic ret_hold, rti_hold;
    for (int i = 0; i < 256; i++) imem[i] = 8'($urandom);
    imem[0] = 8'h40;
    imem[1] = 8'hFF;
    rst_n = 1'b0;
    applyStimulus(0, 0, 8'h00, 0, 0, 0, 0, 8'h00);

    vecs[0]  = '{0,0,8'h00,0,0,0,0,8'h00, 8'h00,8'h00,1,0,2'd0,0,0};
    vecs[1]  = '{0,0,8'h00,0,0,0,0,8'h00, 8'h00,8'h00,1,0,2'd0,0,0};
    vecs[2]  = '{0,0,8'h00,0,0,0,0,8'h00, 8'h00,8'h00,1,1,2'd3,0,0};
    vecs[3]  = '{0,0,8'h00,0,0,0,0,8'h00, 8'h40,8'h40,0,0,2'd0,0,0};
    vecs[4]  = '{0,0,8'h00,0,0,0,0,8'h00, 8'h41,8'h41,0,0,2'd0,0,0};
    vecs[5]  = '{1,1,8'h30,0,0,0,0,8'h00, 8'h42,8'h42,0,0,2'd0,0,0};
    vecs[6]  = '{1,1,8'h30,0,0,0,0,8'h00, 8'h42,8'h42,0,0,2'd0,0,0};
    vecs[7]  = '{0,1,8'h30,0,0,0,0,8'h00, 8'h42,8'h42,0,1,2'd2,1,0};
    vecs[8]  = '{0,0,8'h00,0,0,0,0,8'h00, 8'h30,8'h30,0,0,2'd0,0,0};
    vecs[9]  = '{0,0,8'h00,1,0,0,0,8'h00, 8'h31,8'h31,0,0,2'd0,1,1};
    vecs[10] = '{0,0,8'h00,1,0,0,0,8'h00, 8'h31,8'h31,1,0,2'd0,0,0};
    vecs[11] = '{0,0,8'h00,1,0,0,0,8'h00, 8'h31,8'h01,1,0,2'd0,0,0};
    vecs[12] = '{0,0,8'h00,1,0,0,0,8'h00, 8'h31,8'h31,1,0,2'd0,0,0};
    vecs[13] = '{0,0,8'h00,1,0,0,0,8'h00, 8'h31,8'h31,1,1,2'd0,0,0};
    vecs[14] = '{0,0,8'h00,1,0,0,0,8'h00, 8'hFF,8'hFF,0,0,2'd0,0,0};
    vecs[15] = '{0,0,8'h00,1,0,0,0,8'h00, 8'h00,8'h00,0,0,2'd0,0,0};
    vecs[16] = '{0,0,8'h00,1,1,1,0,8'h00, 8'h01,8'h01,0,0,2'd0,0,0};
    vecs[17] = '{0,0,8'h00,1,1,1,0,8'h00, 8'h01,8'h01,1,0,2'd0,0,0};
    vecs[18] = '{0,0,8'h00,1,1,1,0,8'h00, 8'h01,8'h01,1,0,2'd0,0,0};
    vecs[19] = '{0,0,8'h00,1,1,1,0,8'h00, 8'h01,8'h01,1,0,2'd0,0,0};
    vecs[20] = '{0,0,8'h00,1,1,1,1,8'h31, 8'h01,8'h01,1,1,2'd1,1,0};
    vecs[21] = '{0,0,8'h00,1,0,0,0,8'h00, 8'h31,8'h31,0,0,2'd0,1,1};

    $display("[TB] reset state");
    @(negedge clk); @(negedge clk); #1;
    checkOutput("rst_pc", pc, 8'h00);
    checkOutput("rst_reset_addr", reset_addr, 8'h00);
    checkOutput("rst_interrupt_addr", interrupt_addr, 8'h00);
    checkOutput("rst_busy", 8'(busy), 8'h01);
    checkOutput("rst_pc_src", 8'(pc_src), 8'h00);
    checkOutput("rst_pc_in_sel", 8'(pc_in_sel), 8'h00);
    checkOutput("rst_strobes", 8'({push_req, flush, intr_ack}), 8'h00);
    checkOutput("rst_imem_addr", imem_addr, 8'h00);

    $display("[TB] directed vector table");
    rst_n = 1'b1;
    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i].st, vecs[i].br, vecs[i].baddr, vecs[i].it,
                    vecs[i].rt, vecs[i].ri, vecs[i].sv, vecs[i].sdata);
      #1;
      checkOutput($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
      checkOutput($sformatf("v%0d_imem_addr", i), imem_addr, vecs[i].e_imem);
      checkOutput($sformatf("v%0d_busy", i), 8'(busy), 8'(vecs[i].e_busy));
      checkOutput($sformatf("v%0d_pc_src", i), 8'(pc_src), 8'(vecs[i].e_src));
      checkOutput($sformatf("v%0d_pc_in_sel", i), 8'(pc_in_sel), 8'(vecs[i].e_sel));
      checkOutput($sformatf("v%0d_flush", i), 8'(flush), 8'(vecs[i].e_flush));
      checkOutput($sformatf("v%0d_intr_ack", i), 8'(intr_ack), 8'(vecs[i].e_ack));
      checkOutput($sformatf("v%0d_push_req", i), 8'(push_req), 8'(vecs[i].e_ack));
      if (vecs[i].e_ack) checkOutput($sformatf("v%0d_push_data", i), push_data, vecs[i].e_pc);
      if (i == 3) checkOutput("v3_reset_addr", reset_addr, 8'h40);
      @(negedge clk);
    end

    $display("[TB] reset during interrupt vector capture");
    applyStimulus(0, 0, 8'h00, 0, 0, 0, 0, 8'h00);
    #1;
    checkOutput("int_push_busy", 8'(busy), 8'h01);
    checkOutput("int_push_interrupt_addr", interrupt_addr, 8'hFF);
    @(negedge clk); #1;
    checkOutput("vec_int_imem_addr", imem_addr, 8'h01);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_pc", pc, 8'h00);
    checkOutput("midrst_reset_addr", reset_addr, 8'h00);
    checkOutput("midrst_interrupt_addr", interrupt_addr, 8'h00);
    checkOutput("midrst_imem_addr", imem_addr, 8'h00);
    checkOutput("midrst_busy", 8'(busy), 8'h01);
    imem[0] = 8'h80;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput($sformatf("reboot%0d_busy", c), 8'(busy), 8'h01);
      checkOutput($sformatf("reboot%0d_pc_in_sel", c), 8'(pc_in_sel), (c == 2) ? 8'h03 : 8'h00);
      @(negedge clk);
    end
    #1;
    checkOutput("reboot_pc", pc, 8'h80);
    checkOutput("reboot_busy", 8'(busy), 8'h00);

    $display("[TB] randomized traffic against model");
    imem[0] = 8'($urandom);
    imem[1] = 8'($urandom);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    modelReset();
    rst_n = 1'b1;
    ret_hold = 1'b0;
    rti_hold = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (n != 0) @(negedge clk);
      if (!ret_hold && m_mode == 1 && $urandom_range(0, 9) == 0) begin
        ret_hold = 1'b1;
        rti_hold = 1'($urandom);
      end
      applyStimulus($urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0, 8'($urandom),
                    $urandom_range(0, 3) == 0, ret_hold, rti_hold,
                    $urandom_range(0, 2) == 0, 8'($urandom));
      #1;
      modelStep();
      if (ret_hold && m_mode == 1 && stack_valid && pc_in_sel == 2'b01) ret_hold = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
